fp_div_sqrt_iter: RTL and testbench

- Iterative responder for the fp execution handshake: accepts a one-cycle `enable` pulse carrying normalized mantissas, runs a radix-2 restoring divide or square root one bit per cycle, returns a one-cycle `ready` pulse with raw quotient/root and sticky bit.
- Sits under the fp execution stage behind the fdiv/fsqrt decode; the caller owns exponent handling, special cases, normalization and rounding.

---
 rtl/fp_div_sqrt_iter_if.sv | 25 ++
 rtl/fp_div_sqrt_iter.sv | 153 +++++++++++++++
 tb/tb_fp_div_sqrt_iter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fp_div_sqrt_iter_if.sv
// Handshake bundle between the fp execution stage (master) and the
// iterative divide / square-root unit (slave).
interface fp_div_sqrt_iter_if #(
   parameter int QW = 26
);
   logic          enable;
   logic          op_sqrt;
   logic [23:0]   a_mant;
   logic [23:0]   b_mant;
   logic          sqrt_shift;
   logic          busy;
   logic          ready;
   logic [QW-1:0] q;
   logic          sticky;

   modport master (
      output enable, op_sqrt, a_mant, b_mant, sqrt_shift,
      input  busy, ready, q, sticky
   );

   modport slave (
      input  enable, op_sqrt, a_mant, b_mant, sqrt_shift,
      output busy, ready, q, sticky
   );
endinterface

// File: rtl/fp_div_sqrt_iter.sv
// Radix-2 restoring mantissa divider / square root, one result bit per cycle.
// Divide : q = floor(A*2^25 / B), sticky = remainder != 0.
// Sqrt   : q = floor(sqrt(X*2^27)), X = A << sqrt_shift, sticky = X*2^27 - q^2 != 0.
// Exponents, special cases, normalization and rounding belong to the caller.
module fp_div_sqrt_iter #(
   parameter int QW = 26
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   fp_div_sqrt_iter_if.slave bus
);

   // Partial remainder width: sqrt needs two bits above the root, divide fits easily.
   localparam int RW = QW + 2;
   // Radicand shift register holds X*2^27, consumed two bits per step.
   localparam int XW = 2 * QW;
   localparam int CW = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_r;
   logic            op_r;
   logic [23:0]     b_r;
   logic [XW-1:0]   rad_r;
   logic [RW-1:0]   rem_r;
   logic [QW-1:0]   qacc_r;
   logic [CW-1:0]   cnt_r;
   logic            busy_r;
   logic            ready_r;
   logic [QW-1:0]   q_r;
   logic            sticky_r;

   logic [24:0]     x_s;
   logic [XW-1:0]   rad_ld_s;
   logic [RW-1:0]   rem_ld_s;
   logic [RW-1:0]   cmp_s;
   logic [RW-1:0]   trial_s;
   logic [RW-1:0]   diff_s;
   logic            ge_s;
   logic [RW-1:0]   rem_nxt_s;
   logic [QW-1:0]   qacc_nxt_s;

   assign bus.busy   = busy_r;
   assign bus.ready  = ready_r;
   assign bus.q      = q_r;
   assign bus.sticky = sticky_r;

   // Operand preload: sqrt starts from an empty remainder, divide from the dividend.
   always_comb begin
      x_s      = {25{1'b0}};
      rad_ld_s = {XW{1'b0}};
      rem_ld_s = {RW{1'b0}};
      if (bus.op_sqrt) begin
         x_s      = bus.sqrt_shift ? {bus.a_mant, 1'b0} : {1'b0, bus.a_mant};
         rad_ld_s = {x_s, {(XW-25){1'b0}}};
         rem_ld_s = {RW{1'b0}};
      end else begin
         x_s      = {25{1'b0}};
         rad_ld_s = {XW{1'b0}};
         rem_ld_s = {{(RW-24){1'b0}}, bus.a_mant};
      end
   end

   // One restoring step: trial subtract, keep difference when it does not go negative.
   always_comb begin
      cmp_s   = {RW{1'b0}};
      trial_s = {RW{1'b0}};
      if (op_r) begin
         cmp_s   = {rem_r[RW-3:0], rad_r[XW-1 -: 2]};
         trial_s = {qacc_r, 2'b01};
      end else begin
         cmp_s   = rem_r;
         trial_s = {{(RW-24){1'b0}}, b_r};
      end
      ge_s   = (cmp_s >= trial_s);
      diff_s = cmp_s - trial_s;
      if (op_r) begin
         rem_nxt_s = ge_s ? diff_s : cmp_s;
      end else begin
         // Divide shifts after the step; the final doubled remainder is only tested for zero.
         rem_nxt_s = ge_s ? {diff_s[RW-2:0], 1'b0} : {cmp_s[RW-2:0], 1'b0};
      end
      qacc_nxt_s = {qacc_r[QW-2:0], ge_s};
   end

   // Control FSM with registered handshake outputs and result capture.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r  <= IDLE;
         op_r     <= 1'b0;
         b_r      <= 24'd0;
         rad_r    <= {XW{1'b0}};
         rem_r    <= {RW{1'b0}};
         qacc_r   <= {QW{1'b0}};
         cnt_r    <= {CW{1'b0}};
         busy_r   <= 1'b0;
         ready_r  <= 1'b0;
         q_r      <= {QW{1'b0}};
         sticky_r <= 1'b0;
      end else if (clear) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         ready_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               ready_r <= 1'b0;
               if (bus.enable) begin
                  state_r <= ITER;
                  busy_r  <= 1'b1;
                  op_r    <= bus.op_sqrt;
                  b_r     <= bus.b_mant;
                  rad_r   <= rad_ld_s;
                  rem_r   <= rem_ld_s;
                  qacc_r  <= {QW{1'b0}};
                  cnt_r   <= {CW{1'b0}};
               end else begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            ITER: begin
               if (cnt_r == CW'(QW)) begin
                  state_r  <= DONE;
                  busy_r   <= 1'b0;
                  ready_r  <= 1'b1;
                  q_r      <= qacc_r;
                  sticky_r <= |rem_r;
               end else begin
                  state_r <= ITER;
                  busy_r  <= 1'b1;
                  ready_r <= 1'b0;
                  rem_r   <= rem_nxt_s;
                  qacc_r  <= qacc_nxt_s;
                  rad_r   <= {rad_r[XW-3:0], 2'b00};
                  cnt_r   <= cnt_r + 5'd1;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               ready_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_div_sqrt_iter.sv
// Directed bench for fp_div_sqrt_iter: hand-computed quotients and roots,
// latency, abort, re-entry and reset behaviour.
module tb_fp_div_sqrt_iter;

   localparam int QW = 26;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic clear = 1'b0;
   int   checks = 0;
   int   failures = 0;

   fp_div_sqrt_iter_if #(.QW(QW)) bus ();

   fp_div_sqrt_iter #(.QW(QW)) dut (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic          op;
      logic [23:0]   a;
      logic [23:0]   b;
      logic          sh;
      logic [25:0]   q;
      logic          st;
   } vec_t;

   vec_t vecs [8] = '{
      '{1'b0, 24'h800000, 24'h800000, 1'b0, 26'h2000000, 1'b0},
      '{1'b0, 24'h800000, 24'hC00000, 1'b0, 26'h1555555, 1'b1},
      '{1'b0, 24'hFFFFFF, 24'h800000, 1'b0, 26'h3FFFFFC, 1'b0},
      '{1'b0, 24'h800000, 24'hFFFFFF, 1'b0, 26'h1000001, 1'b1},
      '{1'b1, 24'h800000, 24'h123456, 1'b0, 26'h2000000, 1'b0},
      '{1'b1, 24'h800000, 24'h000000, 1'b1, 26'h2D413CC, 1'b1},
      '{1'b1, 24'h900000, 24'h000000, 1'b1, 26'h3000000, 1'b0},
      '{1'b1, 24'hA20000, 24'h000000, 1'b0, 26'h2400000, 1'b0}
   };

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pulse enable for one edge, then scramble the operand inputs.
   task automatic start_op(input logic op, input logic [23:0] a, input logic [23:0] b, input logic sh);
      @(negedge clock);
      bus.op_sqrt    = op;
      bus.a_mant     = a;
      bus.b_mant     = b;
      bus.sqrt_shift = sh;
      bus.enable     = 1'b1;
      @(posedge clock);
      #1;
      bus.enable     = 1'b0;
      bus.op_sqrt    = ~op;
      bus.a_mant     = ~a;
      bus.b_mant     = ~b;
      bus.sqrt_shift = ~sh;
   endtask

   // Edges until ready is seen (-1 on timeout), and busy-low cycles before it.
   task automatic wait_ready(output int lat, output int gaps);
      lat  = -1;
      gaps = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clock);
         #1;
         if (bus.ready) begin
            lat = i;
            break;
         end
         if (!bus.busy) gaps++;
      end
   endtask

   task automatic count_ready(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         if (bus.ready) cnt++;
      end
   endtask

   initial begin
      int lat;
      int gaps;
      int cnt;

      bus.enable     = 1'b0;
      bus.op_sqrt    = 1'b0;
      bus.a_mant     = 24'd0;
      bus.b_mant     = 24'd0;
      bus.sqrt_shift = 1'b0;

      repeat (3) @(posedge clock);
      #1;
      check("rst_busy",   64'(bus.busy),   64'd0);
      check("rst_ready",  64'(bus.ready),  64'd0);
      check("rst_q",      64'(bus.q),      64'd0);
      check("rst_sticky", 64'(bus.sticky), 64'd0);
      reset = 1'b1;

      for (int v = 0; v < 8; v++) begin
         start_op(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].sh);
         check($sformatf("v%0d_busy_start", v), 64'(bus.busy), 64'd1);
         wait_ready(lat, gaps);
         check($sformatf("v%0d_latency", v),   64'(lat),         64'd27);
         check($sformatf("v%0d_busy_gaps", v), 64'(gaps),        64'd0);
         check($sformatf("v%0d_busy_done", v), 64'(bus.busy),    64'd0);
         check($sformatf("v%0d_q", v),         64'(bus.q),       64'(vecs[v].q));
         check($sformatf("v%0d_sticky", v),    64'(bus.sticky),  64'(vecs[v].st));
         @(posedge clock);
         #1;
         check($sformatf("v%0d_ready_pulse", v), 64'(bus.ready), 64'd0);
      end

      // Abort ten edges after enable; result registers keep the last root.
      start_op(1'b0, 24'h800000, 24'hC00000, 1'b0);
      repeat (9) @(posedge clock);
      #1;
      clear = 1'b1;
      @(posedge clock);
      #1;
      clear = 1'b0;
      check("clr_busy",  64'(bus.busy),  64'd0);
      check("clr_ready", 64'(bus.ready), 64'd0);
      @(negedge clock);
      bus.enable = 1'b1;
      clear      = 1'b1;
      @(posedge clock);
      #1;
      bus.enable = 1'b0;
      clear      = 1'b0;
      check("clr_en_busy", 64'(bus.busy), 64'd0);
      count_ready(35, cnt);
      check("clr_no_ready", 64'(cnt),        64'd0);
      check("clr_q_hold",   64'(bus.q),      64'h2400000);
      check("clr_st_hold",  64'(bus.sticky), 64'd0);
      start_op(1'b0, 24'h800000, 24'h800000, 1'b0);
      wait_ready(lat, gaps);
      check("post_clr_latency", 64'(lat),   64'd27);
      check("post_clr_q",       64'(bus.q), 64'h2000000);

      // A second enable mid-iteration must not disturb the running divide.
      start_op(1'b0, 24'h800000, 24'hC00000, 1'b0);
      repeat (5) @(posedge clock);
      #1;
      bus.op_sqrt = 1'b1;
      bus.a_mant  = 24'hFFFFFF;
      bus.b_mant  = 24'h800000;
      bus.enable  = 1'b1;
      @(posedge clock);
      #1;
      bus.enable = 1'b0;
      wait_ready(lat, gaps);
      check("mid_en_latency", 64'(lat),        64'd21);
      check("mid_en_q",       64'(bus.q),      64'h1555555);
      check("mid_en_sticky",  64'(bus.sticky), 64'd1);
      @(posedge clock);
      #1;
      check("mid_en_no_restart", 64'(bus.busy), 64'd0);

      // Back-to-back: enable during the ready cycle starts the next operation.
      start_op(1'b1, 24'h900000, 24'h000000, 1'b1);
      wait_ready(lat, gaps);
      check("b2b_first_latency", 64'(lat),   64'd27);
      check("b2b_first_q",       64'(bus.q), 64'h3000000);
      bus.op_sqrt    = 1'b0;
      bus.a_mant     = 24'h800000;
      bus.b_mant     = 24'hFFFFFF;
      bus.sqrt_shift = 1'b0;
      bus.enable     = 1'b1;
      @(posedge clock);
      #1;
      bus.enable = 1'b0;
      check("b2b_accept_busy",  64'(bus.busy),  64'd1);
      check("b2b_accept_ready", 64'(bus.ready), 64'd0);
      wait_ready(lat, gaps);
      check("b2b_second_latency", 64'(lat),        64'd27);
      check("b2b_second_q",       64'(bus.q),      64'h1000001);
      check("b2b_second_sticky",  64'(bus.sticky), 64'd1);

      // Reset mid-operation zeroes everything and suppresses the result.
      start_op(1'b0, 24'h800000, 24'hC00000, 1'b0);
      repeat (7) @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
      check("mid_rst_busy",   64'(bus.busy),   64'd0);
      check("mid_rst_ready",  64'(bus.ready),  64'd0);
      check("mid_rst_q",      64'(bus.q),      64'd0);
      check("mid_rst_sticky", 64'(bus.sticky), 64'd0);
      reset = 1'b1;
      count_ready(35, cnt);
      check("mid_rst_no_ready", 64'(cnt), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
